// File: rtl/ahb_ic_pkg.sv
// ---------------------------------------------------------------------------
// ahb_ic_pkg
//   Shared types and constants for the AHB-Lite single-master interconnect.
//   - htrans_t     : AHB transfer type encoding
//   - HRESP_*      : response encodings
//   - err_state_t  : states of the built-in default (error) slave
//   - dsel_t       : data-phase select register encoding. Codes 0..15 name a
//                    real slave; DSEL_NONE and DSEL_DEFAULT sit just above the
//                    largest possible slave index so they never collide.
// ---------------------------------------------------------------------------
package ahb_ic_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ERR1 = 2'd1,
    ERR_ERR2 = 2'd2
  } err_state_t;

  localparam int MAX_SLAVES = 16;
  localparam int DSEL_W     = 5;

  typedef logic [DSEL_W-1:0] dsel_t;

  localparam dsel_t DSEL_NONE    = dsel_t'(MAX_SLAVES);
  localparam dsel_t DSEL_DEFAULT = dsel_t'(MAX_SLAVES + 1);

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY get a
  // zero-wait OKAY from whoever is in the data phase.
  function automatic logic is_active_transfer(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_interconnect_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
//   Built-in error responder. A one-cycle trigger (address landed in an
//   unmapped region, or a slave timed out) starts the standard two-cycle AHB
//   ERROR response. Each completed ERROR bumps a saturating 8-bit counter.
// Ports
//   hclk       in   bus clock
//   hresetn    in   async active-low reset
//   trigger    in   start an ERROR sequence at the next edge
//   active     out  FSM is in ERR1/ERR2 and owns the data phase
//   hready     out  data-phase HREADY while active
//   hresp      out  data-phase HRESP while active
//   err_count  out  saturating count of generated ERROR responses
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_ic_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       trigger,
  output logic       active,
  output logic       hready,
  output logic       hresp,
  output logic [7:0] err_count
);

  err_state_t state;
  err_state_t state_next;

  // State register for the ERROR sequencer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ERR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ERR2 drives HREADY high, so the master may issue its next address there;
  // if that address is unmapped again we chain straight into a fresh ERR1.
  always_comb begin
    state_next = state;
    unique case (state)
      ERR_IDLE: if (trigger) state_next = ERR_ERR1;
      ERR_ERR1: state_next = ERR_ERR2;
      ERR_ERR2: state_next = trigger ? ERR_ERR1 : ERR_IDLE;
      default:  state_next = ERR_IDLE;
    endcase
  end

  // Outputs depend on state only, so the trigger (itself derived from
  // HREADY) never loops back combinationally into HREADY.
  assign active = (state != ERR_IDLE);
  assign hready = (state != ERR_ERR1);
  assign hresp  = (state == ERR_IDLE) ? HRESP_OKAY : HRESP_ERROR;

  // One count per completed ERROR, taken in its final cycle; sticks at 255.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_count <= 8'd0;
    end else if (state == ERR_ERR2 && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// ahb_lite_interconnect
//   Single-master AHB-Lite interconnect: region decoder, data-phase response
//   mux, built-in default slave for unmapped regions and a wait-state
//   watchdog that turns a hung slave into an ERROR response.
// Parameters
//   NUM_SLAVES      attached slaves (1..16); region i selects slave i
//   ADDR_WIDTH      HADDR width
//   DATA_WIDTH      read data width
//   REGION_LSB      region index = HADDR[ADDR_WIDTH-1:REGION_LSB]
//   TIMEOUT_CYCLES  wait cycles tolerated per data phase; 0 disables
// Ports
//   HCLK, HRESETn   clock and async active-low reset
//   HADDR, HTRANS   master address phase
//   HSEL            one-hot slave select (address phase, follows HADDR)
//   HREADYOUT_S     per-slave ready
//   HRESP_S         per-slave response
//   HRDATA_S        packed per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   HREADY, HRESP, HRDATA  muxed data-phase response to the master
//   irq_clr         clears timeout_irq
//   timeout_irq     sticky flag: a slave timed out
//   err_count       saturating count of interconnect-generated ERRORs
// ---------------------------------------------------------------------------
module ahb_lite_interconnect
  import ahb_ic_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REGION_LSB     = 28,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [1:0]                     HTRANS,
  output logic [NUM_SLAVES-1:0]          HSEL,
  input  logic [NUM_SLAVES-1:0]          HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]          HRESP_S,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  output logic                           HREADY,
  output logic                           HRESP,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  input  logic                           irq_clr,
  output logic                           timeout_irq,
  output logic [7:0]                     err_count
);

  localparam int IDX_W     = ADDR_WIDTH - REGION_LSB;
  localparam int IDX_EXT_W = IDX_W + 1;
  localparam int TCNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST =
    TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  // ---------------- address-phase decode ----------------
  logic [IDX_W-1:0]      region_idx;
  logic                  region_hit;
  dsel_t                 target;
  logic [NUM_SLAVES-1:0] hsel_dec;
  htrans_t               htrans_cur;
  logic                  transfer_req;
  logic                  addr_unused;

  assign region_idx   = HADDR[ADDR_WIDTH-1:REGION_LSB];
  // Extra MSB so the compare still works when NUM_SLAVES == 2**IDX_W.
  assign region_hit   = {1'b0, region_idx} < IDX_EXT_W'(NUM_SLAVES);
  assign target       = region_hit ? dsel_t'(region_idx) : DSEL_DEFAULT;
  assign htrans_cur   = htrans_t'(HTRANS);
  assign transfer_req = is_active_transfer(htrans_cur);
  assign addr_unused  = ^HADDR[REGION_LSB-1:0];

  // One-hot select straight from the address; HTRANS does not gate it,
  // slaves qualify HSEL with HTRANS themselves.
  always_comb begin
    hsel_dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (target == dsel_t'(i)) hsel_dec[i] = 1'b1;
    end
  end

  assign HSEL = hsel_dec;

  // ---------------- data-phase select ----------------
  dsel_t                 dsel;
  logic                  hready_int;
  logic                  hresp_int;
  logic [DATA_WIDTH-1:0] hrdata_int;
  logic                  dsel_is_slave;
  logic                  sel_ready;
  logic                  sel_resp;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // The address phase is accepted whenever HREADY is high; idle/busy
  // cycles park the data phase on NONE.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= DSEL_NONE;
    end else if (hready_int) begin
      dsel <= transfer_req ? target : DSEL_NONE;
    end
  end

  assign dsel_is_slave = dsel < dsel_t'(NUM_SLAVES);

  // Pick the outputs of the slave that owns the current data phase.
  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = HRESP_OKAY;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == dsel_t'(i)) begin
        sel_ready = HREADYOUT_S[i];
        sel_resp  = HRESP_S[i];
        sel_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------- default slave / error sequencer ----------------
  logic default_trigger;
  logic timeout_fire;
  logic err_active;
  logic err_hready;
  logic err_hresp;

  // Unmapped transfer is flagged in its address phase so ERR1 lines up with
  // the first data-phase cycle.
  assign default_trigger = hready_int && transfer_req && !region_hit;

  ahb_default_slave u_default_slave (
    .hclk      (HCLK),
    .hresetn   (HRESETn),
    .trigger   (default_trigger || timeout_fire),
    .active    (err_active),
    .hready    (err_hready),
    .hresp     (err_hresp),
    .err_count (err_count)
  );

  // While the error sequencer runs it owns the bus; a late HREADYOUT from a
  // hung slave is ignored.
  always_comb begin
    hready_int = 1'b1;
    hresp_int  = HRESP_OKAY;
    hrdata_int = '0;
    if (err_active) begin
      hready_int = err_hready;
      hresp_int  = err_hresp;
    end else if (dsel_is_slave) begin
      hready_int = sel_ready;
      hresp_int  = sel_resp;
      hrdata_int = sel_rdata;
    end
  end

  assign HREADY = hready_int;
  assign HRESP  = hresp_int;
  assign HRDATA = hrdata_int;

  // ---------------- hung-slave watchdog ----------------
  logic [TCNT_W-1:0] tcnt;
  logic              slave_waiting;

  assign slave_waiting = dsel_is_slave && !err_active && !sel_ready;
  // tcnt counts completed wait cycles, so reaching the last value while the
  // slave is still low means it has stalled for TIMEOUT_CYCLES cycles.
  assign timeout_fire  = (TIMEOUT_CYCLES != 0) && slave_waiting && (tcnt == TCNT_LAST);

  // Restart the count on every accepted address; hold it once it fires so
  // it cannot wrap while the error response plays out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tcnt <= '0;
    end else if (hready_int) begin
      tcnt <= '0;
    end else if (slave_waiting && !timeout_fire) begin
      tcnt <= tcnt + TCNT_W'(1);
    end
  end

  // Sticky interrupt; a new timeout wins over a simultaneous clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      timeout_irq <= 1'b0;
    end else if (timeout_fire) begin
      timeout_irq <= 1'b1;
    end else if (irq_clr) begin
      timeout_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_interconnect
//   Self-checking bench for ahb_lite_interconnect (4 slaves, 8-cycle timeout).
//   Transfers are described at transaction level (address, type, wait states,
//   response, data, hung flag). A reference model expands each transfer into
//   the per-cycle response the master should observe; the bench plays the
//   slave side from the same description and pipelines the next address
//   into the current data phase.
// ---------------------------------------------------------------------------
module tb_ahb_lite_interconnect;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic             HCLK;
  logic             HRESETn;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [NS-1:0]    HSEL;
  logic [NS-1:0]    HREADYOUT_S;
  logic [NS-1:0]    HRESP_S;
  logic [NS*DW-1:0] HRDATA_S;
  logic             HREADY;
  logic             HRESP;
  logic [DW-1:0]    HRDATA;
  logic             irq_clr;
  logic             timeout_irq;
  logic [7:0]       err_count;

  ahb_lite_interconnect #(
    .NUM_SLAVES     (NS),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (DW),
    .REGION_LSB     (28),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_S    (HRDATA_S),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .irq_clr     (irq_clr),
    .timeout_irq (timeout_irq),
    .err_count   (err_count)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    int          waits;
    bit          err;
    logic [31:0] data;
    bit          stuck;
    bit          clr_at_fire;
  } xfer_t;

  typedef struct {
    bit          hready;
    bit          hresp;
    logic [31:0] rdata;
    bit          s_ready;
    bit          s_resp;
    bit          clr;
    bit          chk_irq;
  } beat_t;

  xfer_t xq[$];
  beat_t beats[$];

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_err   = 0;
  bit exp_irq   = 1'b0;

  // Watchdog: every phase is a fixed number of cycles, this only guards
  // against a simulator-level hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no end of test, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] exp_hsel(input logic [31:0] addr);
    logic [3:0] idx;
    idx = addr[31:28];
    return (int'(idx) < NS) ? (32'd1 << idx) : 32'd0;
  endfunction

  function automatic int target_slave(input xfer_t x);
    int idx;
    idx = int'(x.addr[31:28]);
    return (x.trans[1] && idx < NS) ? idx : -1;
  endfunction

  function automatic beat_t mk(input bit r, input bit e, input logic [31:0] d, input bit sr, input bit se);
    beat_t b;
    b.hready  = r;
    b.hresp   = e;
    b.rdata   = d;
    b.s_ready = sr;
    b.s_resp  = se;
    b.clr     = 1'b0;
    b.chk_irq = 1'b0;
    return b;
  endfunction

  // Reference model: what the master should see, cycle by cycle, for one
  // transfer's data phase; also tracks err_count and timeout_irq.
  task automatic build_beats(input xfer_t x);
    int    idx;
    beat_t b;
    beats.delete();
    idx = int'(x.addr[31:28]);
    if (!x.trans[1]) begin
      beats.push_back(mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0));
    end else if (idx >= NS) begin
      beats.push_back(mk(1'b0, 1'b1, 32'd0, 1'b1, 1'b0));
      beats.push_back(mk(1'b1, 1'b1, 32'd0, 1'b1, 1'b0));
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end else if (x.stuck) begin
      for (int i = 0; i < TMO; i++) begin
        b = mk(1'b0, 1'b0, x.data, 1'b0, 1'b0);
        b.clr = x.clr_at_fire && (i == TMO - 1);
        beats.push_back(b);
      end
      b = mk(1'b0, 1'b1, 32'd0, 1'b0, 1'($urandom));
      b.chk_irq = 1'b1;
      beats.push_back(b);
      b = mk(1'b1, 1'b1, 32'd0, 1'b0, 1'($urandom));
      b.chk_irq = 1'b1;
      beats.push_back(b);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      exp_irq = 1'b1;
    end else begin
      for (int i = 0; i < x.waits; i++) beats.push_back(mk(1'b0, 1'b0, x.data, 1'b0, 1'b0));
      if (x.err) begin
        beats.push_back(mk(1'b0, 1'b1, x.data, 1'b0, 1'b1));
        beats.push_back(mk(1'b1, 1'b1, x.data, 1'b1, 1'b1));
      end else begin
        beats.push_back(mk(1'b1, 1'b0, x.data, 1'b1, 1'b0));
      end
    end
  endtask

  // Drives master address and all slave outputs for one cycle. The slave
  // owning the data phase follows the beat; the others drive noise.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans, input int slv,
                               input logic [31:0] sdata, input beat_t b);
    HADDR   = addr;
    HTRANS  = trans;
    irq_clr = b.clr;
    for (int j = 0; j < NS; j++) begin
      if (j == slv) begin
        HREADYOUT_S[j]        = b.s_ready;
        HRESP_S[j]            = b.s_resp;
        HRDATA_S[j*DW +: DW]  = sdata;
      end else begin
        HREADYOUT_S[j]        = 1'($urandom);
        HRESP_S[j]            = 1'($urandom);
        HRDATA_S[j*DW +: DW]  = $urandom;
      end
    end
  endtask

  task automatic drive_cycle(input logic [31:0] addr, input logic [1:0] trans, input int slv,
                             input logic [31:0] sdata, input beat_t b);
    applyStimulus(addr, trans, slv, sdata, b);
    @(negedge HCLK);
    checkOutput("HSEL", 32'(HSEL), exp_hsel(addr));
    checkOutput("HREADY", 32'(HREADY), 32'(b.hready));
    checkOutput("HRESP", 32'(HRESP), 32'(b.hresp));
    checkOutput("HRDATA", HRDATA, b.rdata);
    if (b.chk_irq) checkOutput("timeout_irq_set", 32'(timeout_irq), 32'd1);
    @(posedge HCLK);
    #1;
  endtask

  // Plays the queued transfers back to back, each next address overlapping
  // the previous data phase, then an idle cycle and the status checks.
  task automatic run_queue();
    beat_t idle_b;
    xfer_t nx;
    int    slv;
    idle_b = mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    drive_cycle(xq[0].addr, xq[0].trans, -1, 32'd0, idle_b);
    for (int k = 0; k < xq.size(); k++) begin
      build_beats(xq[k]);
      slv = target_slave(xq[k]);
      if (k + 1 < xq.size()) begin
        nx = xq[k+1];
      end else begin
        nx.addr  = $urandom;
        nx.trans = 2'($urandom_range(0, 1));
      end
      foreach (beats[j]) drive_cycle(nx.addr, nx.trans, slv, xq[k].data, beats[j]);
    end
    drive_cycle($urandom, 2'b00, -1, 32'd0, idle_b);
    checkOutput("err_count", 32'(err_count), 32'(exp_err));
    checkOutput("timeout_irq", 32'(timeout_irq), 32'(exp_irq));
    xq.delete();
  endtask

  function automatic xfer_t mkx(input logic [31:0] a, input logic [1:0] t, input int w, input bit e,
                                input logic [31:0] d, input bit s);
    xfer_t x;
    x.addr = a; x.trans = t; x.waits = w; x.err = e; x.data = d; x.stuck = s;
    x.clr_at_fire = 1'b0;
    return x;
  endfunction

  task automatic clear_irq();
    beat_t b;
    b = mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    b.clr = 1'b1;
    drive_cycle($urandom, 2'b00, -1, 32'd0, b);
    exp_irq = 1'b0;
    checkOutput("irq_clr", 32'(timeout_irq), 32'(exp_irq));
  endtask

  initial begin
    xfer_t x;
    beat_t idle_b;
    idle_b = mk(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

    // Reset values
    HRESETn = 1'b0;
    applyStimulus(32'h0000_0000, 2'b00, -1, 32'd0, idle_b);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    checkOutput("rst_HREADY", 32'(HREADY), 32'd1);
    checkOutput("rst_HRESP", 32'(HRESP), 32'd0);
    checkOutput("rst_HRDATA", HRDATA, 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    checkOutput("rst_timeout_irq", 32'(timeout_irq), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    $display("[TB] slave1 read with 2 wait states");
    xq.push_back(mkx(32'h1000_0004, 2'b10, 2, 1'b0, 32'hCAFE_0001, 1'b0));
    run_queue();

    $display("[TB] unmapped region then IDLE to unmapped region");
    xq.push_back(mkx(32'h7000_0000, 2'b10, 0, 1'b0, 32'd0, 1'b0));
    xq.push_back(mkx(32'h7000_0000, 2'b00, 0, 1'b0, 32'd0, 1'b0));
    run_queue();

    $display("[TB] hung slave2 timeout and irq clear");
    xq.push_back(mkx(32'h2000_0010, 2'b10, 0, 1'b0, 32'h1234_5678, 1'b1));
    run_queue();
    clear_irq();

    $display("[TB] back-to-back OKAY then slave ERROR");
    xq.push_back(mkx(32'h0000_0000, 2'b10, 0, 1'b0, 32'hA5A5_0000, 1'b0));
    xq.push_back(mkx(32'h3000_0000, 2'b11, 1, 1'b1, 32'h5A5A_0003, 1'b0));
    run_queue();

    $display("[TB] timeout with simultaneous irq_clr, then chained default errors");
    x = mkx(32'h1000_0000, 2'b10, 0, 1'b0, 32'h0BAD_F00D, 1'b1);
    x.clr_at_fire = 1'b1;
    xq.push_back(x);
    xq.push_back(mkx(32'hF000_0000, 2'b10, 0, 1'b0, 32'd0, 1'b0));
    xq.push_back(mkx(32'h4000_0000, 2'b11, 0, 1'b0, 32'd0, 1'b0));
    run_queue();
    clear_irq();

    $display("[TB] randomized transfers");
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 12; k++) begin
        x = mkx($urandom, 2'($urandom), $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                $urandom, ($urandom_range(0, 9) == 0));
        xq.push_back(x);
      end
      run_queue();
    end

    $display("[TB] err_count saturation");
    xq.push_back(mkx(32'h3000_0000, 2'b10, 0, 1'b0, 32'h0000_3333, 1'b1));
    for (int k = 0; k < 260; k++) xq.push_back(mkx(32'h8000_0000 | ($urandom & 32'h7FFF_FFFC), 2'b10, 0, 1'b0, 32'd0, 1'b0));
    run_queue();

    $display("[TB] async reset during ERR1");
    applyStimulus(32'h7000_0000, 2'b10, -1, 32'd0, idle_b);
    @(negedge HCLK);
    checkOutput("r6_addr_HREADY", 32'(HREADY), 32'd1);
    @(posedge HCLK);
    #1;
    applyStimulus(32'h0000_0000, 2'b00, -1, 32'd0, idle_b);
    @(negedge HCLK);
    checkOutput("r6_err1_HREADY", 32'(HREADY), 32'd0);
    checkOutput("r6_err1_HRESP", 32'(HRESP), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("r6_async_HREADY", 32'(HREADY), 32'd1);
    checkOutput("r6_async_HRESP", 32'(HRESP), 32'd0);
    checkOutput("r6_async_HRDATA", HRDATA, 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    exp_err = 0;
    exp_irq = 1'b0;
    @(negedge HCLK);
    checkOutput("r6_err_count", 32'(err_count), 32'(exp_err));
    checkOutput("r6_timeout_irq", 32'(timeout_irq), 32'(exp_irq));
    checkOutput("r6_idle_HREADY", 32'(HREADY), 32'd1);
    @(posedge HCLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
